// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: out_diff = (in_a - in_b) mod 2^WIDTH,
//   computed LSB first, one bit per clock, through a single full-subtractor
//   cell with a borrow flop. Operands are taken on a valid/ready handshake
//   and the result is held until the consumer acknowledges it.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers an operand pair
//   out_ready  block can accept (IDLE only)
//   in_a       minuend, sampled on the accept edge
//   in_b       subtrahend, sampled on the accept edge
//   out_valid  result available (DONE only)
//   in_ack     downstream has taken the result
//   out_diff   difference modulo 2^WIDTH
//   out_borrow 1 when in_a < in_b (unsigned)
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             out_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             in_ack,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_borrow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] sa, sb, res, res_next;
   logic [CW-1:0]    cnt;
   logic             br, br_next, d;
   logic             accept, last;

   // Full-subtractor cell on the current LSBs.
   always_comb begin
      d        = sa[0] ^ sb[0] ^ br;
      br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      // Shift-right with the new bit entering the MSB; written this way so
      // it also holds for WIDTH = 1, where there is no upper slice.
      res_next            = res >> 1;
      res_next[WIDTH-1]   = d;
   end

   assign last   = (cnt == CW'(WIDTH - 1));
   assign accept = in_valid & (state == IDLE);

   // Handshake outputs decode from registered state only.
   assign out_ready = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (last)     state_next = DONE;
         DONE:    if (in_ack)   state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa         <= '0;
         sb         <= '0;
         res        <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         out_diff   <= '0;
         out_borrow <= 1'b0;
      end else if (accept) begin
         sa  <= in_a;
         sb  <= in_b;
         res <= '0;
         br  <= 1'b0;
         cnt <= '0;
      end else if (state == RUN) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         res <= res_next;
         br  <= br_next;
         // Counter reaches WIDTH at most, which fits in CW bits.
         cnt <= cnt + 1'b1;
         if (last) begin
            out_diff   <= res_next;
            out_borrow <= br_next;
         end
      end
   end

endmodule
